// File: rtl/throughout_seq_gen.sv
// Stimulus generator for the transport/bus/train window protocol, with optional drop injection.
// Optional window/injection statistics are enabled with the GEN_STATS_EN macro.
module throughout_seq_gen #(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [1:0]       cmd_mode,
  input  logic [LEN_W-1:0] cmd_inj,
  output logic             transport,
  output logic             bus,
  output logic             train,
  output logic             busy,
  output logic             done,
  output logic             exp_pass
`ifdef GEN_STATS_EN
  ,
  output logic [15:0]      win_cnt,
  output logic [15:0]      inj_cnt
`endif
);

  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, GAP} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] inj_q;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] cyc_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [LEN_W-1:0] eff_len_c;

  assign eff_len_c = (cmd_len == '0) ? LEN_W'(1) : cmd_len;

  // {transport, bus, train} for a given ACTIVE-cycle index, with the selected signal dropped
  function automatic logic [2:0] sig_at(input logic [LEN_W-1:0] idx);
    logic [2:0] s;
    s = 3'b111;
    if (idx == inj_q) begin
      case (mode_q)
        2'd1:    s[2] = 1'b0;
        2'd2:    s[1] = 1'b0;
        2'd3:    s[0] = 1'b0;
        default: s = 3'b111;
      endcase
    end
    return s;
  endfunction

  // Outputs are loaded with the values for the state being entered, so they are all registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      inj_q     <= '0;
      mode_q    <= '0;
      cyc_cnt   <= '0;
      gap_cnt   <= '0;
      cmd_ready <= 1'b1;
      transport <= 1'b0;
      bus       <= 1'b0;
      train     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      exp_pass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            len_q     <= eff_len_c;
            inj_q     <= cmd_inj;
            mode_q    <= cmd_mode;
            exp_pass  <= (cmd_mode == 2'd0) || (cmd_inj >= eff_len_c);
            state     <= SETUP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            transport <= 1'b1;
          end
        end
        SETUP: begin
          state   <= ACTIVE;
          cyc_cnt <= '0;
          {transport, bus, train} <= sig_at('0);
        end
        ACTIVE: begin
          if (cyc_cnt == len_q - LEN_W'(1)) begin
            state   <= GAP;
            gap_cnt <= '0;
            done    <= (GAP_CYC == 1);
            {transport, bus, train} <= 3'b000;
          end else begin
            cyc_cnt <= cyc_cnt + LEN_W'(1);
            {transport, bus, train} <= sig_at(cyc_cnt + LEN_W'(1));
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            state     <= IDLE;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
            done    <= (gap_cnt + GAP_W'(1)) == GAP_W'(GAP_CYC - 1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GEN_STATS_EN
  // Saturating counts of completed windows and of windows expected to fail
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      inj_cnt <= '0;
    end else if (done) begin
      if (win_cnt != 16'hFFFF) win_cnt <= win_cnt + 16'd1;
      if (!exp_pass && inj_cnt != 16'hFFFF) inj_cnt <= inj_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_throughout_seq_gen.sv
// Directed, table-driven bench for throughout_seq_gen (optional GEN_STATS_EN checks included).
module tb_throughout_seq_gen;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned GAP   = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic [1:0]       cmd_mode;
  logic [LEN_W-1:0] cmd_inj;
  logic             transport, bus, train, busy, done, exp_pass;
`ifdef GEN_STATS_EN
  logic [15:0]      win_cnt, inj_cnt;
  int               win_exp = 0;
  int               inj_exp = 0;
`endif

  int errors = 0;
  int checks = 0;

  throughout_seq_gen #(.LEN_W(LEN_W), .GAP_CYC(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_mode  (cmd_mode),
    .cmd_inj   (cmd_inj),
    .transport (transport),
    .bus       (bus),
    .train     (train),
    .busy      (busy),
    .done      (done),
    .exp_pass  (exp_pass)
`ifdef GEN_STATS_EN
    ,
    .win_cnt   (win_cnt),
    .inj_cnt   (inj_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [1:0]       mode;
    logic [LEN_W-1:0] inj;
    logic             pass;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Observed vector {transport, bus, train, busy, cmd_ready, done}
  function automatic logic [5:0] obs();
    return {transport, bus, train, busy, cmd_ready, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE and check every cycle of the resulting window
  task automatic run_window(input logic [LEN_W-1:0] len, input logic [1:0] mode,
                            input logic [LEN_W-1:0] inj, input logic pass, input bit hold);
    int         eff;
    int         total;
    logic [2:0] sig;
    eff   = (len == '0) ? 1 : int'(len);
    total = 1 + eff + int'(GAP);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_mode  = mode;
    cmd_inj   = inj;
    tick();
    if (hold) begin
      cmd_len  = 4'hF;
      cmd_mode = 2'd3;
      cmd_inj  = 4'h0;
    end else begin
      cmd_valid = 1'b0;
    end
    for (int c = 1; c <= total; c++) begin
      if (c == 1) sig = 3'b100;
      else if (c <= 1 + eff) begin
        sig = 3'b111;
        if (mode != 2'd0 && (c - 2) == int'(inj)) sig[3 - int'(mode)] = 1'b0;
      end else sig = 3'b000;
      check("window", 32'(obs()), 32'({sig, 1'b1, 1'b0, c == total}));
      if (c == total) check("exp_pass", 32'(exp_pass), 32'(pass));
      tick();
    end
`ifdef GEN_STATS_EN
    win_exp++;
    if (!pass) inj_exp++;
    check("win_cnt", 32'(win_cnt), 32'(win_exp));
    check("inj_cnt", 32'(inj_cnt), 32'(inj_exp));
`endif
    check("idle_after", 32'(obs()), 32'(6'b000010));
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_mode  = '0;
    cmd_inj   = '0;

    vecs[0] = '{len: 4'd3,  mode: 2'd0, inj: 4'd0,  pass: 1'b1};
    vecs[1] = '{len: 4'd4,  mode: 2'd2, inj: 4'd1,  pass: 1'b0};
    vecs[2] = '{len: 4'd2,  mode: 2'd1, inj: 4'd5,  pass: 1'b1};
    vecs[3] = '{len: 4'd0,  mode: 2'd0, inj: 4'd0,  pass: 1'b1};
    vecs[4] = '{len: 4'd0,  mode: 2'd3, inj: 4'd0,  pass: 1'b0};
    vecs[5] = '{len: 4'd15, mode: 2'd1, inj: 4'd14, pass: 1'b0};
    vecs[6] = '{len: 4'd5,  mode: 2'd3, inj: 4'd5,  pass: 1'b1};

    // Reset held three cycles, then idle
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outs", 32'(obs()), 32'(6'b000010));
    check("reset_exp_pass", 32'(exp_pass), 32'd0);
`ifdef GEN_STATS_EN
    check("reset_win_cnt", 32'(win_cnt), 32'd0);
`endif
    tick();
    check("idle_stable", 32'(obs()), 32'(6'b000010));

    foreach (vecs[i]) run_window(vecs[i].len, vecs[i].mode, vecs[i].inj, vecs[i].pass, 1'b0);

    // cmd_valid held through a window with changed fields: capture unaffected
    run_window(4'd3, 2'd0, 4'd2, 1'b1, 1'b1);
    tick();
    cmd_valid = 1'b0;
    check("reaccept_setup", 32'(obs()), 32'(6'b100100));
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("reaccept_len", 32'(n), 32'd17);
    check("reaccept_exp_pass", 32'(exp_pass), 32'd0);
    tick();
`ifdef GEN_STATS_EN
    win_exp++;
    inj_exp++;
    check("reaccept_win_cnt", 32'(win_cnt), 32'(win_exp));
`endif
    check("reaccept_idle", 32'(obs()), 32'(6'b000010));

    // Reset during the second ACTIVE cycle of a len=5 window
    cmd_valid = 1'b1;
    cmd_len   = 4'd5;
    cmd_mode  = 2'd0;
    cmd_inj   = 4'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_active0", 32'(obs()), 32'(6'b111100));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset_outs", 32'(obs()), 32'(6'b000010));
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) n++;
      tick();
    end
    check("mid_reset_no_done", 32'(n), 32'd0);
`ifdef GEN_STATS_EN
    check("mid_reset_win_cnt", 32'(win_cnt), 32'd0);
    check("mid_reset_inj_cnt", 32'(inj_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/throughout_seq_gen.md
Name: throughout_seq_gen

Overview:
- Stimulus generator for the transport/bus/train window protocol. The checker side samples `transport throughout (bus && train)` with first_match; this block drives those three signals.
- On command it emits one framed window:
  - transport held high for the whole window;
  - bus and train asserted together for a programmable number of cycles;
  - optionally one signal dropped at a chosen cycle, so the checker sees a known violation.
- Sits in the assertion bench next to the checker. Reports the verdict the checker must produce for each window.

Parameters:
- LEN_W, 4: width of window-length and inject-cycle fields.
- GAP_CYC, 1: idle cycles (all outputs low) after each window; minimum 1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_len  input  LEN_W  ACTIVE cycles; 0 treated as 1.
- cmd_mode  input  2  0 = legal, 1 = drop transport, 2 = drop bus, 3 = drop train.
- cmd_inj  input  LEN_W  ACTIVE-cycle index (0-based) at which the drop occurs.
- transport  output  1  driven window qualifier.
- bus  output  1  driven condition A.
- train  output  1  driven condition B.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on the last GAP cycle.
- exp_pass  output  1  expected checker verdict; valid while done=1.

Behaviour:
- Reset: when rst is high at a posedge:
  - state goes to IDLE and all counters clear;
  - transport=bus=train=0, busy=0, done=0, exp_pass=0, cmd_ready=1 from the next cycle.
  - Reset mid-window aborts the window; no done is produced.
- Command capture: on accept, len, mode and inj are registered. Later changes on cmd_* have no effect until the next IDLE.
- State machine:
  - IDLE: all outputs 0. Accept moves to SETUP next cycle.
  - SETUP (1 cycle): transport=1, bus=0, train=0. Then ACTIVE.
  - ACTIVE (len cycles): transport=bus=train=1, except in the cycle where the cycle counter equals inj and mode≠0, where the selected signal is 0. Exactly one cycle is dropped; the signal returns to 1 afterwards. After the last cycle, go to GAP.
  - GAP (GAP_CYC cycles): all three signals 0. done=1 on the last GAP cycle, then IDLE.
- Latency:
  - accept edge to transport=1: 1 cycle;
  - to bus&&train=1: 2 cycles;
  - total window: 1 + len + GAP_CYC cycles.
- Injection range: inj ≥ len means the drop never happens and the window is legal.
- exp_pass: registered at accept as (mode==0) || (inj ≥ eff_len), where eff_len = max(cmd_len, 1). Held until the next accept.
- No back-to-back commands: cmd_ready is 0 from the accept cycle until IDLE is re-entered. Earliest next accept is the cycle after done.
- Counter width: LEN_W; no wrap, since maximum len is 2^LEN_W − 1.
- All outputs are registered; no combinational path from cmd_* to the outputs.

Optional Feature:
- Macro: GEN_STATS_EN.
- Defined:
  - adds outputs win_cnt[15:0] (completed windows, incremented with done) and inj_cnt[15:0] (windows with exp_pass=0, incremented with done);
  - both saturate at 16'hFFFF and clear on rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then idle: rst held high 3 cycles, then released. All outputs are 0 and cmd_ready=1.
- Legal window, len=3, mode=0, accept at T:
  - transport=1 at T+1..T+4;
  - bus=train=1 at T+2..T+4;
  - done at T+5 with exp_pass=1;
  - cmd_ready returns at T+6.
- Drop bus: len=4, mode=2, inj=1. In the second ACTIVE cycle bus=0 while transport=train=1. exp_pass=0 at done.
- Out-of-range injection: len=2, mode=1, inj=5. No drop occurs and exp_pass=1.
- Boundary and ignored command:
  - len=0 behaves as len=1: one ACTIVE cycle.
  - cmd_valid held high during busy is ignored; the next accept happens only after done.
- Reset mid-window: rst during ACTIVE cycle 2 of len=5. Next cycle all outputs are 0 and no done pulse occurs. With GEN_STATS_EN defined, win_cnt=0 after reset.
